// File: rtl/mem_access_pkg.sv
// mem_access_pkg: MemDataType encodings and FSM state type for the load/store unit
package mem_access_pkg;
  localparam logic [1:0] MDT_BYTE = 2'b00;
  localparam logic [1:0] MDT_HALF = 2'b01;
  localparam logic [1:0] MDT_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module mem_lane_align (
  input  logic [1:0]  typ,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  import mem_access_pkg::*;
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;
  // shift the selected lane down for loads, splice the low store bits into it for RMW
  always_comb begin
    sh = (typ == MDT_BYTE) ? {lane, 3'b000} : {lane[1], 4'b0000};
    shifted = rdata >> sh;
    mask = (typ == MDT_BYTE) ? 32'h0000_00ff : 32'h0000_ffff;
    load_data = (typ >= MDT_WORD) ? rdata :
                (typ == MDT_BYTE) ? {{24{~uns & shifted[7]}}, shifted[7:0]} :
                                    {{16{~uns & shifted[15]}}, shifted[15:0]};
    merge_data = (typ >= MDT_WORD) ? wdata : (rdata & ~(mask << sh)) | ((wdata & mask) << sh);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit with req/ack memory handshake, RMW sub-word stores and ack watchdog (optional ALIGN_CHECK_EN)
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            MemDataType,
  input  logic                  LoadUnsigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Stall,
  output logic                  Done,
  output logic                  AddrErr,
  output logic                  BusErr,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [31:0]           MemWData,
  input  logic [31:0]           MemRData,
  input  logic                  MemAck
);
  import mem_access_pkg::*;
  state_t      state, state_n;
  logic [1:0]  typ_q, lane_q;
  logic        uns_q, wr_q, aerr_q, berr_q;
  logic [31:0] wdata_q, wd, load_data, merge_data;
  logic        req, mis, accept, timeout;
  assign req    = MemRead | MemWrite;
  assign accept = (state == IDLE) && req;
`ifdef ALIGN_CHECK_EN
  assign mis = (MemDataType >= MDT_WORD) ? (Address[1:0] != 2'b00) : (MemDataType == MDT_HALF) && Address[0];
`else
  assign mis = 1'b0;
`endif
  assign timeout = (TIMEOUT_CYCLES != 0) && !MemAck && (wd == 32'(TIMEOUT_CYCLES - 1));
  assign MemReq  = (state == RD) || (state == WR);
  assign MemWe   = state == WR;
  assign Done    = state == DONE;
  assign Stall   = MemReq || accept;
  assign AddrErr = Done & aerr_q;
  assign BusErr  = Done & berr_q;
  mem_lane_align u_align (
    .typ        (typ_q),
    .uns        (uns_q),
    .lane       (lane_q),
    .rdata      (MemRData),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );
  // state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end
  // next state: loads and sub-word stores read first, word stores go straight to write
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req) state_n = mis ? DONE : (MemWrite && MemDataType >= MDT_WORD) ? WR : RD;
      RD:      if (MemAck) state_n = wr_q ? WR : DONE;
               else if (timeout) state_n = DONE;
      WR:      if (MemAck || timeout) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // request latch, per-phase watchdog, load result and RMW merge capture
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wd       <= '0;
      typ_q    <= '0;
      lane_q   <= '0;
      uns_q    <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      aerr_q   <= 1'b0;
      berr_q   <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      ReadData <= '0;
    end else begin
      wd <= (MemReq && state_n == state) ? wd + 32'd1 : 32'd0;
      if (accept) begin
        typ_q    <= MemDataType;
        lane_q   <= Address[1:0];
        uns_q    <= LoadUnsigned;
        wr_q     <= MemWrite;
        wdata_q  <= WriteData;
        aerr_q   <= mis;
        berr_q   <= 1'b0;
        MemAddr  <= {Address[ADDR_WIDTH-1:2], 2'b00};
        MemWData <= WriteData;
      end
      if (state == RD && MemAck) begin
        if (wr_q) MemWData <= merge_data;
        else      ReadData <= load_data;
      end else if (MemReq && timeout) begin
        berr_q   <= 1'b1;
        ReadData <= '0;
      end
    end
  end
endmodule
